// File: rtl/decode_ctrl_pkg.sv
// Shared decode definitions: RV32I opcodes, immediate selects, ALU ops, ID/EX control bundle.
package decode_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] IMM_I  = 3'b000;
    localparam logic [2:0] IMM_S  = 3'b001;
    localparam logic [2:0] IMM_B  = 3'b010;
    localparam logic [2:0] IMM_J  = 3'b011;
    localparam logic [2:0] IMM_U  = 3'b100;
    localparam logic [2:0] IMM_SH = 3'b101;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic       vld;
        logic       rd_wren;
        logic       mem_rd;
        logic       mem_wren;
        logic       br;
        logic       jmp;
        logic       opa_pc;
        logic       opb_imm;
        alu_op_e    alu_op;
        logic [4:0] rd;
        logic       illegal;
    } idex_ctrl_t;

    // Register-register ops use funct7[5] to select SUB; immediate ops never subtract.
    function automatic alu_op_e alu_dec(input logic [2:0] funct3, input logic b30,
                                        input logic allow_sub);
        case (funct3)
            3'b000:  alu_dec = (allow_sub && b30) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = b30 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_ctrl_hazard_detect.sv
// Load-use hazard detection; purely combinational.
module hazard_detect
    import decode_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       instr_vld,
    input  logic       flush,
    input  logic       ex_vld,
    input  logic       ex_mem_rd,
    input  logic [4:0] ex_rd,
    output logic       stall
);

    logic rs1_used;
    logic rs2_used;
    logic load_use;

    // Source-register usage by opcode, then match against the load in EX.
    always_comb begin
        rs1_used = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
        rs2_used = (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH);
        load_use = instr_vld && ex_vld && ex_mem_rd && (ex_rd != 5'd0) &&
                   ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));
        // A taken branch kills the dependent instruction anyway, so no stall.
        stall    = load_use && !flush;
    end

endmodule

// File: rtl/decode_ctrl.sv
// Instruction decode, ID/EX control register and stall/flush event counters.
module decode_ctrl
    import decode_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_instr,
    input  logic             i_instr_vld,
    input  logic             i_flush,
    output logic [2:0]       o_imm_sel,
    output logic             o_stall,
    output logic             o_flush_ifid,
    output logic             o_ex_vld,
    output logic             o_ex_rd_wren,
    output logic             o_ex_mem_rd,
    output logic             o_ex_mem_wren,
    output logic             o_ex_br,
    output logic             o_ex_jmp,
    output logic             o_ex_opa_pc,
    output logic             o_ex_opb_imm,
    output logic [3:0]       o_ex_alu_op,
    output logic [4:0]       o_ex_rd,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    idex_ctrl_t dec;
    idex_ctrl_t ex;
    logic       unused_instr;

    assign opcode       = i_instr[6:0];
    assign funct3       = i_instr[14:12];
    assign unused_instr = ^{i_instr[31], i_instr[29:25]};

    hazard_detect u_hazard (
        .opcode    (opcode),
        .rs1       (i_instr[19:15]),
        .rs2       (i_instr[24:20]),
        .instr_vld (i_instr_vld),
        .flush     (i_flush),
        .ex_vld    (ex.vld),
        .ex_mem_rd (ex.mem_rd),
        .ex_rd     (ex.rd),
        .stall     (o_stall)
    );

    assign o_flush_ifid = i_flush;

    // Decode opcode into immediate select and the control bundle for EX.
    always_comb begin
        dec       = '0;
        o_imm_sel = IMM_I;
        dec.vld   = 1'b1;
        dec.rd    = i_instr[11:7];
        case (opcode)
            OPC_LOAD: begin
                dec.rd_wren = 1'b1; dec.mem_rd = 1'b1; dec.opb_imm = 1'b1;
            end
            OPC_OPIMM: begin
                dec.rd_wren = 1'b1; dec.opb_imm = 1'b1;
                dec.alu_op  = alu_dec(funct3, i_instr[30], 1'b0);
                if (funct3 == 3'b001 || funct3 == 3'b101) o_imm_sel = IMM_SH;
            end
            OPC_OP: begin
                dec.rd_wren = 1'b1;
                dec.alu_op  = alu_dec(funct3, i_instr[30], 1'b1);
            end
            OPC_STORE: begin
                dec.mem_wren = 1'b1; dec.opb_imm = 1'b1; o_imm_sel = IMM_S;
            end
            OPC_BRANCH: begin
                dec.br = 1'b1; dec.alu_op = ALU_SUB; o_imm_sel = IMM_B;
            end
            OPC_JAL: begin
                dec.rd_wren = 1'b1; dec.jmp = 1'b1; dec.opa_pc = 1'b1;
                dec.opb_imm = 1'b1; o_imm_sel = IMM_J;
            end
            OPC_JALR: begin
                dec.rd_wren = 1'b1; dec.jmp = 1'b1; dec.opb_imm = 1'b1;
            end
            OPC_LUI: begin
                dec.rd_wren = 1'b1; dec.opb_imm = 1'b1; dec.alu_op = ALU_PASSB;
                o_imm_sel = IMM_U;
            end
            OPC_AUIPC: begin
                dec.rd_wren = 1'b1; dec.opa_pc = 1'b1; dec.opb_imm = 1'b1;
                o_imm_sel = IMM_U;
            end
            default: dec.illegal = 1'b1;
        endcase
        // x0 writes are dropped; rd is only carried when it will be written.
        if (dec.rd == 5'd0) dec.rd_wren = 1'b0;
        if (!dec.rd_wren)   dec.rd      = 5'd0;
    end

    // ID/EX register: bubble on flush, stall or empty IF/ID.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                ex <= '0;
        else if (i_flush || o_stall || !i_instr_vld) ex <= '0;
        else                                         ex <= dec;
    end

    // Saturating stall/flush event counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else begin
            if (o_stall && !(&o_stall_cnt)) o_stall_cnt <= o_stall_cnt + CNT_W'(1);
            if (i_flush && !(&o_flush_cnt)) o_flush_cnt <= o_flush_cnt + CNT_W'(1);
        end
    end

    assign o_ex_vld      = ex.vld;
    assign o_ex_rd_wren  = ex.rd_wren;
    assign o_ex_mem_rd   = ex.mem_rd;
    assign o_ex_mem_wren = ex.mem_wren;
    assign o_ex_br       = ex.br;
    assign o_ex_jmp      = ex.jmp;
    assign o_ex_opa_pc   = ex.opa_pc;
    assign o_ex_opb_imm  = ex.opb_imm;
    assign o_ex_alu_op   = ex.alu_op;
    assign o_ex_rd       = ex.rd;
    assign o_illegal     = ex.illegal;

endmodule
